// File: rtl/npc_regfile_pkg.sv
// Shared types, constants and the write-port match helper for the NPC register file.
package npc_regfile_pkg;

  // Default geometry of the architectural register file
  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;

  // Index of the hard-wired zero register
  localparam int REG_ZERO = 0;

  // Upper bounds on the write port count and address width. The helper works on
  // vectors padded to these sizes so that one function serves every configuration.
  localparam int MAX_WRITE      = 2;
  localparam int MAX_ADDR_WIDTH = 12;
  localparam int PORT_IDX_WIDTH = (MAX_WRITE > 1) ? $clog2(MAX_WRITE) : 1;

  // Result of a write-port search: whether any enabled port targets the address,
  // and which port supplies the data when several do
  typedef struct packed {
    logic                      hit;
    logic [PORT_IDX_WIDTH-1:0] port;
  } write_pick_t;

  // Returns the highest-index enabled write port whose address equals addr.
  // Later loop iterations overwrite earlier ones, so the highest index wins.
  function automatic write_pick_t pick_write(
    input logic [MAX_WRITE-1:0]                wen,
    input logic [MAX_WRITE*MAX_ADDR_WIDTH-1:0] waddr,
    input logic [MAX_ADDR_WIDTH-1:0]           addr
  );
    write_pick_t result;
    result = '0;
    for (int i = 0; i < MAX_WRITE; i++) begin
      if (wen[i] && (waddr[i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH] == addr)) begin
        result.hit  = 1'b1;
        result.port = PORT_IDX_WIDTH'(i);
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: same-cycle write bypass, zero-register override and
// ready/busy indication for the register being read.
module regfile_read_port
  import npc_regfile_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_WRITE  = 1,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]               raddr,
  input  logic [MAX_WRITE-1:0]                wen,
  input  logic [MAX_WRITE*MAX_ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH-1:0]               stored,
  input  logic                                stored_busy,
  output logic [DATA_WIDTH-1:0]               rdata,
  output logic                                rbusy
);

  write_pick_t pick;
  logic        is_zero;

  // Select stored value or in-flight write data, and derive readiness from the scoreboard
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    pick    = pick_write(wen, waddr, MAX_ADDR_WIDTH'(raddr));
    is_zero = ZERO_REG && (raddr == ADDR_WIDTH'(REG_ZERO));
    rdata   = stored;
    rbusy   = stored_busy;
    if (is_zero) begin
      // The zero register never carries data or a pending producer
      rdata = '0;
      rbusy = 1'b0;
    end else if (BYPASS && pick.hit) begin
      // The value being written this cycle is forwarded and therefore ready
      rdata = wdata[int'(pick.port)*DATA_WIDTH +: DATA_WIDTH];
      rbusy = 1'b0;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port general-purpose register file with zero register, optional write-to-read
// bypass and a per-register busy scoreboard for multi-cycle producers.
module regfile_mp
  import npc_regfile_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int                    DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int                    NUM_READ    = 2,
  parameter int                    NUM_WRITE   = 1,
  parameter bit                    ZERO_REG    = 1'b1,
  parameter bit                    BYPASS      = 1'b1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_WRITE-1:0]           wen,
  input  logic [NUM_WRITE*ADDR_WIDTH-1:0] waddr,
  input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] raddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] rdata,
  output logic [NUM_READ-1:0]            rbusy,
  input  logic                           alloc_en,
  input  logic [ADDR_WIDTH-1:0]          alloc_addr,
  output logic [(1<<ADDR_WIDTH)-1:0]     busy_vec
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0]               mem [DEPTH];
  logic [DEPTH-1:0]                    busy;
  logic [NUM_WRITE-1:0]                wen_eff;
  logic [MAX_WRITE-1:0]                wen_pad;
  logic [MAX_WRITE*MAX_ADDR_WIDTH-1:0] waddr_pad;

  // Writes presented while reset is held must not reach the read ports either
  assign wen_eff = rst ? wen : '0;

  // Widen the write-port bundle to the fixed shape the match helper expects
  always_comb begin
    wen_pad   = '0;
    waddr_pad = '0;
    for (int i = 0; i < NUM_WRITE; i++) begin
      wen_pad[i] = wen_eff[i];
      waddr_pad[i*MAX_ADDR_WIDTH +: MAX_ADDR_WIDTH] =
        MAX_ADDR_WIDTH'(waddr[i*ADDR_WIDTH +: ADDR_WIDTH]);
    end
  end

  // Storage and scoreboard, one slice per register
  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    if (ZERO_REG && (e == REG_ZERO)) begin : g_zero
      assign mem[e]  = '0;
      assign busy[e] = 1'b0;
    end else begin : g_reg
      write_pick_t           pick;
      logic                  alloc_hit;
      logic [DATA_WIDTH-1:0] value;
      logic                  pending;

      // Decode which write port (if any) and whether the allocator target this entry
      always_comb begin
        pick      = pick_write(wen_pad, waddr_pad, MAX_ADDR_WIDTH'(e));
        alloc_hit = alloc_en && (alloc_addr == ADDR_WIDTH'(e));
      end

      // Capture write data and track a pending producer; allocation beats a clearing write
      always_ff @(posedge clk or negedge rst) begin
        // NOTE: the register file is built from flops with async reset because the
        // contents must read RESET_VALUE as soon as reset asserts, not at the next edge.
        if (!rst) begin
          value   <= RESET_VALUE;
          pending <= 1'b0;
        end else begin
          // NOTE: non-blocking assignments keep every slice sampling pre-edge state.
          if (pick.hit) begin
            value <= wdata[int'(pick.port)*DATA_WIDTH +: DATA_WIDTH];
          end
          if (alloc_hit) begin
            pending <= 1'b1;
          end else if (pick.hit) begin
            pending <= 1'b0;
          end
        end
      end

      assign mem[e]  = value;
      assign busy[e] = pending;
    end
  end

  assign busy_vec = busy;

  // One read port per requested reader
  for (genvar j = 0; j < NUM_READ; j++) begin : g_read
    logic [ADDR_WIDTH-1:0] addr;
    assign addr = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];

    regfile_read_port #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NUM_WRITE  (NUM_WRITE),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_port (
      .raddr       (addr),
      .wen         (wen_pad),
      .waddr       (waddr_pad),
      .wdata       (wdata),
      .stored      (mem[addr]),
      .stored_busy (busy[addr]),
      .rdata       (rdata[j*DATA_WIDTH +: DATA_WIDTH]),
      .rbusy       (rbusy[j])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Scoreboard bench for regfile_mp: a bypassing and a non-bypassing instance share
// stimulus and are compared against one reference model of storage and busy bits.
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NW = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NW-1:0]     wen = '0;
  logic [NW*AW-1:0]  waddr = '0;
  logic [NW*DW-1:0]  wdata = '0;
  logic [NR*AW-1:0]  raddr = '0;
  logic              alloc_en = 1'b0;
  logic [AW-1:0]     alloc_addr = '0;

  logic [NR*DW-1:0]  rdata_b, rdata_n;
  logic [NR-1:0]     rbusy_b, rbusy_n;
  logic [DEPTH-1:0]  busy_b, busy_n;

  always #5 clk = ~clk;

  regfile_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW),
    .ZERO_REG(1'b1), .BYPASS(1'b1), .RESET_VALUE(32'h0)
  ) dut_byp (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_b)
  );

  regfile_mp #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_READ(NR), .NUM_WRITE(NW),
    .ZERO_REG(1'b1), .BYPASS(1'b0), .RESET_VALUE(32'h0)
  ) dut_nob (
    .clk(clk), .rst(rst), .wen(wen), .waddr(waddr), .wdata(wdata),
    .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_vec(busy_n)
  );

  // Reference state
  logic [DW-1:0]    m_mem [DEPTH];
  logic [DEPTH-1:0] m_busy;

  typedef struct {
    logic [NR*DW-1:0] rd_b;
    logic [NR*DW-1:0] rd_n;
    logic [NR-1:0]    rb_b;
    logic [NR-1:0]    rb_n;
    logic [DEPTH-1:0] bv;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
    m_busy = '0;
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    logic [DW-1:0] d;
    if (a == 0) return '0;
    d = m_mem[a];
    if (byp && rst)
      for (int i = 0; i < NW; i++)
        if (wen[i] && waddr[i*AW +: AW] == a) d = wdata[i*DW +: DW];
    return d;
  endfunction

  function automatic logic exp_busy(input logic [AW-1:0] a, input bit byp);
    logic b;
    if (a == 0) return 1'b0;
    b = m_busy[a];
    if (byp && rst)
      for (int i = 0; i < NW; i++)
        if (wen[i] && waddr[i*AW +: AW] == a) b = 1'b0;
    return b;
  endfunction

  function automatic exp_t predict();
    exp_t e;
    for (int j = 0; j < NR; j++) begin
      e.rd_b[j*DW +: DW] = exp_data(raddr[j*AW +: AW], 1'b1);
      e.rd_n[j*DW +: DW] = exp_data(raddr[j*AW +: AW], 1'b0);
      e.rb_b[j]          = exp_busy(raddr[j*AW +: AW], 1'b1);
      e.rb_n[j]          = exp_busy(raddr[j*AW +: AW], 1'b0);
    end
    e.bv = m_busy;
    return e;
  endfunction

  // Clock-edge update of the reference: port order gives the higher index priority,
  // allocation is applied after the clear so it wins
  task automatic model_edge();
    for (int i = 0; i < NW; i++)
      if (wen[i]) begin
        if (waddr[i*AW +: AW] != 0) m_mem[waddr[i*AW +: AW]] = wdata[i*DW +: DW];
        m_busy[waddr[i*AW +: AW]] = 1'b0;
      end
    if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
    m_busy[0] = 1'b0;
  endtask

  // Called just after a rising edge with inputs already driven
  task automatic run_cycle(input string tag);
    exp_t e;
    sb.push_back(predict());
    @(negedge clk);
    e = sb.pop_front();
    check({tag, "/rdata_byp"}, 128'(rdata_b), 128'(e.rd_b));
    check({tag, "/rdata_nob"}, 128'(rdata_n), 128'(e.rd_n));
    check({tag, "/rbusy_byp"}, 128'(rbusy_b), 128'(e.rb_b));
    check({tag, "/rbusy_nob"}, 128'(rbusy_n), 128'(e.rb_n));
    check({tag, "/busy_byp"},  128'(busy_b),  128'(e.bv));
    check({tag, "/busy_nob"},  128'(busy_n),  128'(e.bv));
    @(posedge clk);
    if (rst) model_edge();
    #1;
  endtask

  task automatic idle();
    wen = '0; alloc_en = 1'b0;
  endtask

  task automatic wr(input int port, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wen[port] = 1'b1;
    waddr[port*AW +: AW] = a;
    wdata[port*DW +: DW] = d;
  endtask

  task automatic rd_all(input logic [AW-1:0] a);
    for (int j = 0; j < NR; j++) raddr[j*AW +: AW] = a;
  endtask

  // Watchdog: the run is a few thousand cycles; anything longer is a hang
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(posedge clk); #1;
    run_cycle("reset0");
    run_cycle("reset1");
    rst = 1'b1;

    // Write x5 with a same-cycle read: bypass sees it now, the other next cycle
    idle(); wr(0, 5'd5, 32'hDEADBEEF); rd_all(5'd5);
    run_cycle("wr_x5");
    idle();
    run_cycle("rd_x5");

    // Same-cycle bypass of x7 on read port 0
    wr(0, 5'd7, 32'hCAFE0001); raddr[0 +: AW] = 5'd7;
    run_cycle("byp_x7");
    idle();
    run_cycle("rd_x7");

    // Both ports target x3; port 1 wins in storage and on the bypass
    wr(0, 5'd3, 32'h1); wr(1, 5'd3, 32'h2); rd_all(5'd3);
    run_cycle("prio_x3");
    idle();
    run_cycle("rd_x3");

    // Zero register: write and allocate are both discarded
    wr(0, 5'd0, 32'h12345678); alloc_en = 1'b1; alloc_addr = 5'd0; rd_all(5'd0);
    run_cycle("zero_wr");
    idle();
    run_cycle("zero_rd");

    // Scoreboard: allocate, then write+alloc together keeps it busy, then write clears
    alloc_en = 1'b1; alloc_addr = 5'd9; rd_all(5'd9);
    run_cycle("alloc_x9");
    idle();
    run_cycle("busy_x9");
    wr(0, 5'd9, 32'h99); alloc_en = 1'b1; alloc_addr = 5'd9;
    run_cycle("wr_alloc_x9");
    idle();
    run_cycle("still_busy_x9");
    wr(1, 5'd9, 32'h9A);
    run_cycle("clear_x9");
    idle();
    run_cycle("free_x9");

    // Leave x12 busy, then assert reset mid-cycle and look before any edge
    alloc_en = 1'b1; alloc_addr = 5'd12;
    run_cycle("alloc_x12");
    idle(); rd_all(5'd5);
    run_cycle("pre_rst_x5");
    rst = 1'b0;
    #1;
    check("async_rst/x5", 128'(rdata_b[DW-1:0]), 128'(32'h0));
    check("async_rst/busy_vec", 128'(busy_b), 128'(0));
    check("async_rst/rbusy", 128'(rbusy_b), 128'(0));
    model_reset();
    // Write and allocation across an edge while reset is held
    wr(0, 5'd6, 32'h55); alloc_en = 1'b1; alloc_addr = 5'd6; rd_all(5'd6);
    run_cycle("in_rst");
    rst = 1'b1; idle();
    run_cycle("post_rst_x6");

    // Randomised traffic with collisions biased in
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NW; i++) begin
        wen[i] = ($urandom_range(0, 2) != 0);
        waddr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 3))
                                                         : AW'($urandom_range(0, DEPTH-1));
        wdata[i*DW +: DW] = $urandom;
      end
      for (int j = 0; j < NR; j++)
        raddr[j*AW +: AW] = ($urandom_range(0, 2) == 0) ? waddr[($urandom_range(0, NW-1))*AW +: AW]
                                                         : AW'($urandom_range(0, DEPTH-1));
      alloc_en = ($urandom_range(0, 2) == 0);
      alloc_addr = ($urandom_range(0, 1) == 0) ? waddr[0 +: AW] : AW'($urandom_range(0, DEPTH-1));
      run_cycle($sformatf("rand%0d", c));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port general-purpose register file for the NPC core, the next generation of the current 5-bit/32-bit `RegisterFile`. It adds configurable read and write port counts, a hard-wired zero register, optional same-cycle write-to-read bypass, and a per-register busy scoreboard for multi-cycle producers such as load and multiply. It sits between decode (read addresses and allocation) and writeback (write ports), and is clocked alongside the PC register.

## Interface
Parameters:
- `ADDR_WIDTH`, default 5: register index width; depth is 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 32: register width.
- `NUM_READ`, default 2: read port count, from 1 to 4.
- `NUM_WRITE`, default 1: write port count, 1 or 2.
- `ZERO_REG`, default 1: when 1, entry 0 reads as zero, ignores writes and is never busy.
- `BYPASS`, default 1: when 1, a write in the current cycle is visible on the read ports in that same cycle.
- `RESET_VALUE`, default 0: reset contents of every entry.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `wen`  in  NUM_WRITE  per-port write enable.
- `waddr`  in  NUM_WRITE*ADDR_WIDTH  write addresses, packed; port 0 in the LSBs.
- `wdata`  in  NUM_WRITE*DATA_WIDTH  write data, packed.
- `raddr`  in  NUM_READ*ADDR_WIDTH  read addresses, packed.
- `rdata`  out  NUM_READ*DATA_WIDTH  read data, combinational.
- `rbusy`  out  NUM_READ  busy flag of each read-port register.
- `alloc_en`  in  1  mark `alloc_addr` as pending.
- `alloc_addr`  in  ADDR_WIDTH  register gaining a pending producer.
- `busy_vec`  out  2^ADDR_WIDTH  registered scoreboard, one bit per entry.

## Operation
- **Write:** on the rising edge with `wen[i]=1`, `mem[waddr[i]] <= wdata[i]`.
  - If two ports target the same address, the higher port index wins.
  - With `ZERO_REG=1`, writes to address 0 are discarded.
- **Read:** purely combinational.
  - With `BYPASS=1`, if any enabled write port matches `raddr[j]`, `rdata[j]` returns that port's `wdata` (highest matching index). Otherwise it returns `mem[raddr[j]]`.
  - With `BYPASS=0`, `rdata[j]` is always `mem[raddr[j]]`.
  - With `ZERO_REG=1`, address 0 always reads 0, and a bypass to address 0 is suppressed.
- **Scoreboard:**
  - `alloc_en` sets `busy[alloc_addr]` at the edge.
  - Any enabled write clears `busy[waddr[i]]` at the edge.
  - If allocation and write hit the same address in the same cycle, allocation wins and the bit stays set (a new producer supersedes).
  - Allocating an already-busy register leaves it busy.
  - With `ZERO_REG=1`, allocation to address 0 is ignored and `busy[0]` stays 0.
- **`rbusy[j]`:**
  - With `BYPASS=1`: `busy[raddr[j]]` AND NOT (an enabled write to `raddr[j]` this cycle). The bypassed value is treated as ready.
  - With `BYPASS=0`: `busy[raddr[j]]`.
- **Reset:** while `rst=0`, asynchronously:
  - all entries are forced to `RESET_VALUE` (entry 0 reads 0 when `ZERO_REG=1`);
  - `busy_vec` is forced to all-zero, so every `rbusy` is 0.
  - `rdata` follows the reset contents immediately.
  - Writes and allocations presented during reset are ignored.
  - The first edge after reset deasserts performs normal updates.

## Timing
- Write latency: 1 cycle to storage; 0 cycles to read ports with `BYPASS=1`, 1 cycle with `BYPASS=0`.
- Read latency: 0 cycles (combinational from `raddr`, `mem`, `wen`, `waddr`, `wdata`).
- Scoreboard: `busy_vec` changes 1 edge after `alloc_en` or a write.
- No handshake stalls. The producer must hold `alloc_en` for exactly one cycle per allocation.
- Critical path with `BYPASS=1`: address compare → `NUM_WRITE`:1 priority mux → 2^ADDR_WIDTH:1 read mux.

## Structure
- Shared package `npc_regfile_pkg` contains:
  - default `ADDR_WIDTH`/`DATA_WIDTH` constants (5/32);
  - the `REG_ZERO` index constant;
  - a function `pick_write(wen, waddr, addr)` returning the highest-index matching write port plus a hit flag. Both the bypass and the scoreboard clear logic use it.
- One sub-module, `regfile_read_port`, per read port. It holds the bypass mux, zero override and `rbusy` generation, and is instantiated `NUM_READ` times with a generate loop.
- Storage and scoreboard stay in `regfile_mp`.

## Test plan
1. **Reset values:** `RESET_VALUE=32'h0` with `rst=0` asserted mid-run after writing `x5=32'hDEADBEEF` → `rdata` for x5 reads 0 immediately, `busy_vec=0`.
2. **Zero register:** write `x0=32'h12345678`, allocate x0, read x0 → `rdata=0`, `rbusy=0`, `busy_vec[0]=0`.
3. **Same-cycle bypass:** with `BYPASS=1`, `wen=1`, `waddr=7`, `wdata=32'hCAFE0001`, `raddr0=7` in the same cycle → `rdata0=32'hCAFE0001` that cycle. With `BYPASS=0` → old value that cycle, new value next cycle.
4. **Write-port priority:** with `NUM_WRITE=2`, both ports write x3 (port0 `32'h1`, port1 `32'h2`) → the next read of x3 returns `32'h2`, and the bypass also returns `32'h2`.
5. **Scoreboard:** allocate x9 → `busy_vec[9]=1` next cycle. Then, in one cycle, write x9 while `alloc_en` targets x9 → bit stays 1. A later write alone clears it, and `rbusy` drops in the write cycle when `BYPASS=1`.
6. **Randomised reference:** 2000 random cycles against a reference model with `NUM_READ=4`, `NUM_WRITE=2` → all `rdata`, `rbusy` and `busy_vec` match.
